// File: rtl/operand_queue_multicast.sv
// Credit-managed operand queue that routes each instruction's operand words to one consumer.
// Holds a command FIFO of {len, target}, a data FIFO, a read-credit counter and a per-command element counter.
module operand_queue_multicast #(
    parameter int unsigned DataWidth    = 64,
    parameter int unsigned DataBufDepth = 4,
    parameter int unsigned CmdBufDepth  = 4,
    parameter int unsigned NrConsumers  = 2,
    parameter int unsigned CntWidth     = 16,
    localparam int unsigned TgtW        = (NrConsumers > 1) ? $clog2(NrConsumers) : 1,
    localparam int unsigned DCntW       = $clog2(DataBufDepth + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    input  logic [CntWidth-1:0]    cmd_len_i,
    input  logic [TgtW-1:0]        cmd_target_i,
    input  logic                   cmd_valid_i,
    output logic                   cmd_ready_o,
    input  logic                   operand_issued_i,
    output logic                   operand_queue_ready_o,
    input  logic [DataWidth-1:0]   operand_i,
    input  logic                   operand_valid_i,
    output logic [DataWidth-1:0]   operand_o,
    output logic [NrConsumers-1:0] operand_valid_o,
    output logic                   operand_last_o,
    input  logic [NrConsumers-1:0] operand_ready_i,
    output logic [DCntW-1:0]       data_count_o
);

    localparam int unsigned DPtrW = (DataBufDepth > 1) ? $clog2(DataBufDepth) : 1;
    localparam int unsigned CPtrW = (CmdBufDepth > 1) ? $clog2(CmdBufDepth) : 1;
    localparam int unsigned CCntW = $clog2(CmdBufDepth + 1);

    logic [DataWidth-1:0] data_mem [DataBufDepth];
    logic [CntWidth-1:0]  len_mem  [CmdBufDepth];
    logic [TgtW-1:0]      tgt_mem  [CmdBufDepth];

    logic [DPtrW-1:0]    data_wr_q, data_wr_d, data_rd_q, data_rd_d;
    logic [DCntW-1:0]    data_cnt_q, data_cnt_d;
    logic [CPtrW-1:0]    cmd_wr_q, cmd_wr_d, cmd_rd_q, cmd_rd_d;
    logic [CCntW-1:0]    cmd_cnt_q, cmd_cnt_d;
    logic                cmd_full_q, cmd_full_d;
    logic [DCntW-1:0]    credit_q, credit_d;
    logic [CntWidth-1:0] elem_cnt_q, elem_cnt_d;

    logic                   data_empty, data_full, cmd_empty;
    logic [CntWidth-1:0]    head_len;
    logic [TgtW-1:0]        head_tgt;
    logic                   head_zero, head_active, head_last;
    logic [NrConsumers-1:0] valid_vec;
    logic                   handshake;
    logic                   data_push, data_pop, cmd_push, cmd_pop, issue;

    function automatic logic [DPtrW-1:0] data_ptr_inc(input logic [DPtrW-1:0] p);
        return (p == DPtrW'(DataBufDepth - 1)) ? '0 : p + DPtrW'(1);
    endfunction

    function automatic logic [CPtrW-1:0] cmd_ptr_inc(input logic [CPtrW-1:0] p);
        return (p == CPtrW'(CmdBufDepth - 1)) ? '0 : p + CPtrW'(1);
    endfunction

    assign data_empty = (data_cnt_q == '0);
    assign data_full  = (data_cnt_q == DCntW'(DataBufDepth));
    assign cmd_empty  = (cmd_cnt_q == '0);

    assign head_len    = len_mem[cmd_rd_q];
    assign head_tgt    = tgt_mem[cmd_rd_q];
    assign head_zero   = (head_len == '0);
    // Flush suppresses valid so that no handshake can happen in the flush cycle.
    assign head_active = !flush_i && !cmd_empty && !head_zero && !data_empty;
    assign head_last   = (elem_cnt_q == head_len - CntWidth'(1));

    genvar gi;
    generate
        for (gi = 0; gi < NrConsumers; gi++) begin : g_route
            assign valid_vec[gi] = head_active && (head_tgt == TgtW'(gi));
        end
    endgenerate

    assign handshake = |(valid_vec & operand_ready_i);
    assign data_pop  = handshake;
    assign cmd_pop   = !flush_i && !cmd_empty && (head_zero || (handshake && head_last));
    assign cmd_push  = cmd_valid_i && cmd_ready_o;
    assign data_push = !flush_i && operand_valid_i && (!data_full || data_pop);
    assign issue     = !flush_i && operand_issued_i && (credit_q != '0);

    assign cmd_ready_o           = !cmd_full_q && !flush_i;
    assign operand_queue_ready_o = (credit_q != '0);
    assign operand_valid_o       = valid_vec;
    assign operand_last_o        = head_active && head_last;
    assign operand_o             = data_empty ? '0 : data_mem[data_rd_q];
    assign data_count_o          = data_cnt_q;

    always_comb begin
        data_wr_d  = data_wr_q;
        data_rd_d  = data_rd_q;
        data_cnt_d = data_cnt_q;
        cmd_wr_d   = cmd_wr_q;
        cmd_rd_d   = cmd_rd_q;
        cmd_cnt_d  = cmd_cnt_q;
        credit_d   = credit_q;
        elem_cnt_d = elem_cnt_q;

        if (data_push) data_wr_d = data_ptr_inc(data_wr_q);
        if (data_pop)  data_rd_d = data_ptr_inc(data_rd_q);
        case ({data_push, data_pop})
            2'b10:   data_cnt_d = data_cnt_q + DCntW'(1);
            2'b01:   data_cnt_d = data_cnt_q - DCntW'(1);
            default: data_cnt_d = data_cnt_q;
        endcase

        if (cmd_push) cmd_wr_d = cmd_ptr_inc(cmd_wr_q);
        if (cmd_pop)  cmd_rd_d = cmd_ptr_inc(cmd_rd_q);
        case ({cmd_push, cmd_pop})
            2'b10:   cmd_cnt_d = cmd_cnt_q + CCntW'(1);
            2'b01:   cmd_cnt_d = cmd_cnt_q - CCntW'(1);
            default: cmd_cnt_d = cmd_cnt_q;
        endcase

        // Credit goes back to the requester once the word leaves the data FIFO.
        case ({issue, data_pop})
            2'b10:   credit_d = credit_q - DCntW'(1);
            2'b01:   credit_d = credit_q + DCntW'(1);
            default: credit_d = credit_q;
        endcase

        if (handshake) elem_cnt_d = head_last ? '0 : elem_cnt_q + CntWidth'(1);

        if (flush_i) begin
            data_wr_d  = '0;
            data_rd_d  = '0;
            data_cnt_d = '0;
            cmd_wr_d   = '0;
            cmd_rd_d   = '0;
            cmd_cnt_d  = '0;
            credit_d   = DCntW'(DataBufDepth);
            elem_cnt_d = '0;
        end

        cmd_full_d = (cmd_cnt_d == CCntW'(CmdBufDepth));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_wr_q  <= '0;
            data_rd_q  <= '0;
            data_cnt_q <= '0;
            cmd_wr_q   <= '0;
            cmd_rd_q   <= '0;
            cmd_cnt_q  <= '0;
            cmd_full_q <= 1'b0;
            credit_q   <= DCntW'(DataBufDepth);
            elem_cnt_q <= '0;
        end else begin
            data_wr_q  <= data_wr_d;
            data_rd_q  <= data_rd_d;
            data_cnt_q <= data_cnt_d;
            cmd_wr_q   <= cmd_wr_d;
            cmd_rd_q   <= cmd_rd_d;
            cmd_cnt_q  <= cmd_cnt_d;
            cmd_full_q <= cmd_full_d;
            credit_q   <= credit_d;
            elem_cnt_q <= elem_cnt_d;
        end
    end

    // Storage arrays carry no reset; occupancy counters decide what is meaningful.
    always_ff @(posedge clk_i) begin
        if (data_push) data_mem[data_wr_q] <= operand_i;
    end

    always_ff @(posedge clk_i) begin
        if (cmd_push) begin
            len_mem[cmd_wr_q] <= cmd_len_i;
            tgt_mem[cmd_wr_q] <= cmd_target_i;
        end
    end

    a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i || flush_i)
        operand_valid_i |-> (!data_full || data_pop));

    a_no_issue_without_credit: assert property (@(posedge clk_i) disable iff (rst_i || flush_i)
        operand_issued_i |-> (credit_q != '0));

endmodule
